// File: rtl/posit_quire_acc.sv
// Quire-style dot-product accumulator: decodes posit products into QW-bit fixed point
// (QF fractional bits) and sums them exactly, emitting one result per in_last-terminated group.
module posit_quire_acc #(
  parameter int N  = 16,
  parameter int es = 3,
  parameter int QW = 64,
  parameter int QF = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  input  logic          in_inf,
  input  logic          in_zero,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_acc,
  output logic          out_nar,
  output logic          out_ovf,
  output logic [15:0]   out_count,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds its payload stable while valid && !ready.

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam int RW        = N - 1;
  localparam int FW        = RW - es;
  localparam int OVF_SCALE = QW - QF - 1;
  localparam logic [QW-1:0] MAX_POS = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] MIN_NEG = {1'b1, {(QW-1){1'b0}}};

  logic [1:0]    state;
  logic          accept;
  logic          s1_valid, s1_sign, s1_inf, s1_zero, s1_last;
  logic [RW-1:0] s1_mag;
  logic          s2_valid, s2_inf, s2_ovf, s2_last;
  logic [QW-1:0] s2_val;
  logic [QW-1:0] acc;
  logic          nar, ovf;
  logic [15:0]   count;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_acc   = acc;
  assign out_nar   = nar;
  assign out_ovf   = ovf;
  assign out_count = count;
  assign dbg_state = state;

  // Decode of the registered magnitude into an aligned, signed fixed-point term.
  logic [RW-1:0] rest;
  logic [es-1:0] exp_bits;
  logic [FW-1:0] frac;
  logic [QW-1:0] mant_w, mag_al, aligned;
  logic          term_ovf, run_on;
  int            m_i, k_i, scale_i, sh_i;

  always_comb begin
    m_i    = 0;
    run_on = 1'b1;
    for (int i = RW - 1; i >= 0; i--) begin
      if (run_on && (s1_mag[i] == s1_mag[RW-1])) m_i = m_i + 1;
      else run_on = 1'b0;
    end
    k_i      = s1_mag[RW-1] ? (m_i - 1) : -m_i;
    // Drop the regime run and its terminator; vacated positions read as zero.
    rest     = (s1_mag << m_i) << 1;
    exp_bits = rest[RW-1 -: es];
    frac     = rest[FW-1:0];
    scale_i  = k_i * (1 << es) + int'(exp_bits);
    sh_i     = scale_i - FW + QF;
    mant_w   = QW'({1'b1, frac});
    term_ovf = 1'b0;
    if (scale_i >= OVF_SCALE) begin
      mag_al   = MAX_POS;
      term_ovf = 1'b1;
    end else if (sh_i >= 0) begin
      mag_al = mant_w << sh_i;
    end else begin
      mag_al = mant_w >> (-sh_i);
    end
    aligned = s1_sign ? -mag_al : mag_al;
    if (s1_zero || s1_inf) begin
      aligned  = '0;
      term_ovf = 1'b0;
    end
  end

  logic [QW-1:0] sum, acc_next;
  logic          add_ovf;

  always_comb begin
    sum      = acc + s2_val;
    add_ovf  = (acc[QW-1] == s2_val[QW-1]) && (sum[QW-1] != acc[QW-1]);
    acc_next = add_ovf ? (acc[QW-1] ? MIN_NEG : MAX_POS) : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_last   <= 1'b0;
      s1_mag    <= '0;
      s2_valid  <= 1'b0;
      s2_inf    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_last   <= 1'b0;
      s2_val    <= '0;
      acc       <= '0;
      nar       <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sign <= in_posit[N-1];
        s1_inf  <= in_inf;
        s1_zero <= in_zero;
        s1_last <= in_last;
        // Low bits of a two's complement negation depend only on the low bits.
        s1_mag  <= in_posit[N-1] ? -in_posit[RW-1:0] : in_posit[RW-1:0];
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_val  <= aligned;
        s2_inf  <= s1_inf;
        s2_ovf  <= term_ovf;
        s2_last <= s1_last;
      end
      if (s2_valid) begin
        acc <= acc_next;
        ovf <= ovf | add_ovf | s2_ovf;
        nar <= nar | s2_inf;
      end
      case (state)
        ACCUM:  if (accept && in_last) state <= DRAIN;
        DRAIN:  if (s2_valid && s2_last) begin
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
          nar       <= 1'b0;
          ovf       <= 1'b0;
          count     <= '0;
          state     <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_quire_acc.sv
// Bench for posit_quire_acc: table vectors, hand sequences for backpressure and reset,
// and a random stream checked against a posit-decoding reference model.
module tb_posit_quire_acc;

  localparam int N  = 16;
  localparam int ES = 3;
  localparam int QW = 64;
  localparam int QF = 32;
  localparam logic signed [65:0] MAXV = (66'sd1 <<< 63) - 66'sd1;
  localparam logic signed [65:0] MINV = -(66'sd1 <<< 63);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_inf, in_zero, in_last;
  logic [N-1:0]  in_posit;
  logic          out_valid, out_ready, out_nar, out_ovf;
  logic [QW-1:0] out_acc;
  logic [15:0]   out_count;
  logic [1:0]    dbg_state;

  posit_quire_acc #(.N(N), .es(ES), .QW(QW), .QF(QF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
    .in_inf(in_inf), .in_zero(in_zero), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_nar(out_nar), .out_ovf(out_ovf), .out_count(out_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] posit;
    logic        inf;
    logic        zero;
    logic        last;
    logic [63:0] acc;
    logic        nar;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[9];

  int          checks = 0;
  int          errors = 0;
  logic [81:0] exp_q[$];
  logic [63:0] m_acc;
  logic        m_nar, m_ovf;
  logic [15:0] m_cnt;
  logic        ready_exp;
  int          lat = -1;
  logic        use_table;
  logic [81:0] table_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: walk the posit bit string, build 1.f as an integer, scale by 2^(scale-nf+QF).
  function automatic void model_term(input logic [15:0] p, input logic inf, input logic zero,
                                     output logic [63:0] val, output logic tovf);
    logic [15:0]  mag;
    logic         first;
    logic [127:0] v;
    logic [63:0]  mv;
    int i, m, k, e, nf, scale, sh;
    mag   = p[15] ? (16'd0 - p) : p;
    first = mag[14];
    m = 0;
    i = 14;
    while (i >= 0) begin
      if (mag[i] != first) break;
      m++;
      i--;
    end
    i--;
    k = first ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      if (i >= 0) e = e * 2 + int'(mag[i]);
      else e = e * 2;
      i--;
    end
    v  = 128'd1;
    nf = 0;
    while (i >= 0) begin
      v = {v[126:0], mag[i]};
      nf++;
      i--;
    end
    scale = k * (1 << ES) + e;
    tovf  = 1'b0;
    if (inf || zero) begin
      mv = 64'd0;
    end else if (scale >= QW - QF - 1) begin
      mv   = 64'h7FFF_FFFF_FFFF_FFFF;
      tovf = 1'b1;
    end else begin
      sh = scale - nf + QF;
      if (sh >= 0) v = v << sh;
      else v = v >> (-sh);
      mv = v[63:0];
    end
    val = p[15] ? (64'd0 - mv) : mv;
  endfunction

  task automatic model_clear();
    m_acc = '0;
    m_nar = 1'b0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_accept();
    logic [63:0]       val;
    logic              tovf, aovf;
    logic signed [65:0] s;
    model_term(in_posit, in_inf, in_zero, val, tovf);
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    s = $signed({{2{m_acc[63]}}, m_acc}) + $signed({{2{val[63]}}, val});
    aovf = 1'b0;
    if (s > MAXV) begin
      m_acc = 64'h7FFF_FFFF_FFFF_FFFF;
      aovf  = 1'b1;
    end else if (s < MINV) begin
      m_acc = 64'h8000_0000_0000_0000;
      aovf  = 1'b1;
    end else begin
      m_acc = s[63:0];
    end
    m_nar = m_nar | in_inf;
    m_ovf = m_ovf | tovf | aovf;
    if (in_last) begin
      exp_q.push_back(use_table ? table_exp : {m_acc, m_nar, m_ovf, m_cnt});
      model_clear();
      ready_exp = 1'b0;
      lat = 0;
    end
  endtask

  // One cycle: compare outputs at the negedge, predict this edge's transfers, advance.
  task automatic tick();
    logic acc_beat, hs;
    if (out_valid === 1'b1) begin
      if (lat >= 0) begin
        check("latency", 64'(lat), 64'd3);
        lat = -1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0");
      end else begin
        check("out_acc", out_acc, exp_q[0][81:18]);
        check("out_nar", 64'(out_nar), 64'(exp_q[0][17]));
        check("out_ovf", 64'(out_ovf), 64'(exp_q[0][16]));
        check("out_count", 64'(out_count), 64'(exp_q[0][15:0]));
      end
    end else if (lat >= 3) begin
      check("latency", 64'(lat), 64'd3);
      lat = -1;
    end
    check("in_ready", 64'(in_ready), 64'(ready_exp));
    acc_beat = in_valid && in_ready && !rst;
    hs       = out_valid && out_ready && !rst;
    if (rst) begin
      model_clear();
      exp_q.delete();
      ready_exp = 1'b1;
      lat = -1;
    end
    if (hs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      ready_exp = 1'b1;
    end
    if (acc_beat) model_accept();
    @(posedge clk);
    @(negedge clk);
    if (lat >= 0) lat++;
  endtask

  task automatic send_beat(input logic [15:0] p, input logic inf, input logic zero, input logic last);
    logic got;
    int   n;
    in_valid = 1'b1;
    in_posit = p;
    in_inf   = inf;
    in_zero  = zero;
    in_last  = last;
    n = 0;
    do begin
      got = in_ready;
      tick();
      n++;
    end while (!got && n < 100);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic got, pending;
    int   beats, cyc, r;

    vecs[0] = '{16'h4000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{16'h4400, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{16'h4200, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{16'hC000, 1'b0, 1'b0, 1'b1, 64'h0000_0003_8000_0000, 1'b0, 1'b0, 16'd4};
    vecs[4] = '{16'h3C00, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{16'h0000, 1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 16'd2};
    vecs[6] = '{16'h0001, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 16'd1};
    vecs[7] = '{16'h7FFF, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 16'd1};
    vecs[8] = '{16'h8000, 1'b1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 16'd1};

    rst = 1'b1;
    in_valid = 1'b0; in_posit = '0; in_inf = 1'b0; in_zero = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    use_table = 1'b0;
    table_exp = '0;
    ready_exp = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_acc", out_acc, 64'd0);
    check("rst_out_nar", 64'(out_nar), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    use_table = 1'b1;
    for (int i = 0; i < 9; i++) begin
      table_exp = {vecs[i].acc, vecs[i].nar, vecs[i].ovf, vecs[i].cnt};
      send_beat(vecs[i].posit, vecs[i].inf, vecs[i].zero, vecs[i].last);
    end
    drain();

    // Backpressure: result held, input beats ignored, next group starts from zero.
    out_ready = 1'b0;
    table_exp = {64'h0000_0001_0000_0000, 1'b0, 1'b0, 16'd1};
    send_beat(16'h4000, 1'b0, 1'b0, 1'b1);
    in_posit = 16'h4400;
    in_last  = 1'b1;
    r = 0;
    while (out_valid !== 1'b1 && r < 10) begin
      tick();
      r++;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (5) tick();
    check("bp_held_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_valid_fall", 64'(out_valid), 64'd0);
    table_exp = {64'h0000_0002_0000_0000, 1'b0, 1'b0, 16'd1};
    send_beat(16'h4400, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset while two terms are still in the pipeline.
    send_beat(16'h4000, 1'b0, 1'b0, 1'b0);
    send_beat(16'h4200, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_count", 64'(out_count), 64'd0);
    repeat (4) tick();
    table_exp = {64'h0000_0001_0000_0000, 1'b0, 1'b0, 16'd1};
    send_beat(16'h4000, 1'b0, 1'b0, 1'b1);
    drain();
    use_table = 1'b0;

    // Random stream against the reference model.
    beats = 0;
    cyc = 0;
    pending = 1'b0;
    while (beats < 1000 && cyc < 30000) begin
      if (!pending) begin
        r = $urandom_range(0, 15);
        if (r == 0) in_posit = 16'h0000;
        else if (r == 1) in_posit = 16'h8000;
        else in_posit = 16'($urandom_range(0, 65535));
        in_zero = (in_posit == 16'h0000);
        in_inf  = (in_posit == 16'h8000);
        in_last = (beats == 999) || ($urandom_range(0, 5) == 0);
        pending = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      got = in_valid && in_ready;
      tick();
      cyc++;
      if (got) begin
        pending = 1'b0;
        beats++;
      end
    end
    check("random_beats", 64'(beats), 64'd1000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
